// File: rtl/rs_pkg.sv
// Shared definitions for the reservation stations: unit-code tag bases,
// FU opcodes and the default-width entry layout.
package rs_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 8;
    localparam int RS_OP_W   = 3;

    // Tag space is split by producing unit; VALUE marks "no producer".
    localparam logic [7:0] UNIT_SW    = 8'h00;
    localparam logic [7:0] UNIT_ADD   = 8'h20;
    localparam logic [7:0] UNIT_MUL   = 8'h40;
    localparam logic [7:0] UNIT_VALUE = 8'h7F;
    localparam logic [7:0] UNIT_LW    = 8'h80;

    typedef enum logic [RS_OP_W-1:0] {
        FU_LW  = 3'd0,
        FU_SW  = 3'd1,
        FU_ADD = 3'd2,
        FU_SUB = 3'd3,
        FU_MUL = 3'd4
    } fu_op_e;

    // One station slot at the default widths.
    typedef struct packed {
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-1:0]  dst_tag;
        logic                 s1_rdy;
        logic [RS_TAG_W-1:0]  s1_tag;
        logic [RS_DATA_W-1:0] s1_val;
        logic                 s2_rdy;
        logic [RS_TAG_W-1:0]  s2_tag;
        logic [RS_DATA_W-1:0] s2_val;
    } rs_entry_t;

endpackage

// File: rtl/res_station_pq_if.sv
// Dispatch, CDB and issue signals of one reservation station.
interface res_station_pq_if #(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8,
    parameter int OP_W    = 3,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
);
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_dst_tag;
    logic              disp_s1_rdy;
    logic [TAG_W-1:0]  disp_s1_tag;
    logic [DATA_W-1:0] disp_s1_val;
    logic              disp_s2_rdy;
    logic [TAG_W-1:0]  disp_s2_tag;
    logic [DATA_W-1:0] disp_s2_val;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic              iss_valid;
    logic              iss_ready;
    logic [OP_W-1:0]   iss_op;
    logic [TAG_W-1:0]  iss_dst_tag;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic [CNT_W-1:0]  count;

    // Dispatch/CDB/FU side.
    modport master (
        output flush, disp_valid, disp_op, disp_dst_tag,
               disp_s1_rdy, disp_s1_tag, disp_s1_val,
               disp_s2_rdy, disp_s2_tag, disp_s2_val,
               cdb_valid, cdb_tag, cdb_val, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_dst_tag, iss_a, iss_b, count
    );

    // Station side.
    modport slave (
        input  flush, disp_valid, disp_op, disp_dst_tag,
               disp_s1_rdy, disp_s1_tag, disp_s1_val,
               disp_s2_rdy, disp_s2_tag, disp_s2_val,
               cdb_valid, cdb_tag, cdb_val, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_dst_tag, iss_a, iss_b, count
    );
endinterface

// File: rtl/rs_oldest_pick.sv
// Find-first-set from bit 0: index 0 is the oldest slot of the station.
module rs_oldest_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] idx
);
    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/res_station_pq.sv
// Collapsing-queue reservation station: captures operands from the CDB and
// offers the oldest fully-ready entry to its functional unit.
module res_station_pq
    import rs_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = RS_DATA_W,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    res_station_pq_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    // Same layout as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst_tag;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_val;
    } entry_t;

    entry_t             q     [ENTRIES];
    entry_t             q_up  [ENTRIES];
    entry_t             q_nxt [ENTRIES];
    entry_t             disp_ent;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   wr_idx;
    logic               lock_vld;
    logic [IDX_W-1:0]   lock_idx;
    logic [ENTRIES-1:0] elig;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               iss_valid;
    logic               iss_fire;
    logic               disp_ready;
    logic               disp_fire;

    // A waiting source whose tag is on the CDB takes the broadcast value.
    function automatic entry_t capture(entry_t e, logic v, logic [TAG_W-1:0] t,
                                       logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        if (v && !e.s1_rdy && e.s1_tag == t) begin
            r.s1_rdy = 1'b1;
            r.s1_val = d;
        end
        if (v && !e.s2_rdy && e.s2_tag == t) begin
            r.s2_rdy = 1'b1;
            r.s2_val = d;
        end
        return r;
    endfunction

    for (genvar i = 0; i < ENTRIES; i++) begin : g_elig
        assign elig[i] = (CNT_W'(i) < cnt) && q[i].s1_rdy && q[i].s2_rdy;
    end

    rs_oldest_pick #(.N(ENTRIES), .IW(IDX_W)) u_pick (
        .vec   (elig),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A stalled offer keeps its slot even if an older entry becomes ready.
    assign sel_idx    = lock_vld ? lock_idx : pick_idx;
    assign iss_valid  = lock_vld | pick_found;
    assign iss_fire   = iss_valid && bus.iss_ready;
    assign disp_ready = cnt < CNT_W'(ENTRIES);
    assign disp_fire  = bus.disp_valid && disp_ready;
    assign wr_idx     = cnt - CNT_W'(iss_fire);

    assign bus.disp_ready = disp_ready;
    assign bus.iss_valid  = iss_valid;
    assign bus.count      = cnt;

    // Offered entry straight from its registers; zero when nothing is offered.
    always_comb begin
        bus.iss_op      = '0;
        bus.iss_dst_tag = '0;
        bus.iss_a       = '0;
        bus.iss_b       = '0;
        if (iss_valid) begin
            bus.iss_op      = q[sel_idx].op;
            bus.iss_dst_tag = q[sel_idx].dst_tag;
            bus.iss_a       = q[sel_idx].s1_val;
            bus.iss_b       = q[sel_idx].s2_val;
        end
    end

    // Incoming entry, with same-cycle CDB bypass on its waiting sources.
    always_comb begin
        disp_ent.op      = bus.disp_op;
        disp_ent.dst_tag = bus.disp_dst_tag;
        disp_ent.s1_rdy  = bus.disp_s1_rdy;
        disp_ent.s1_tag  = bus.disp_s1_tag;
        disp_ent.s1_val  = bus.disp_s1_val;
        disp_ent.s2_rdy  = bus.disp_s2_rdy;
        disp_ent.s2_tag  = bus.disp_s2_tag;
        disp_ent.s2_val  = bus.disp_s2_val;
        disp_ent = capture(disp_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    end

    // Neighbour above each slot, used when the queue collapses.
    always_comb begin
        for (int i = 0; i < ENTRIES - 1; i++) q_up[i] = q[i + 1];
        q_up[ENTRIES-1] = q[ENTRIES-1];
    end

    // Collapse above the issued slot, capture CDB into the new position,
    // then place any dispatch at the top of the surviving entries.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            q_nxt[i] = q[i];
            if (iss_fire && IDX_W'(i) >= sel_idx) q_nxt[i] = q_up[i];
            q_nxt[i] = capture(q_nxt[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            if (disp_fire && wr_idx == CNT_W'(i)) q_nxt[i] = disp_ent;
        end
    end

    // Slot storage, occupancy and offer lock; flush clears like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
            cnt      <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
            cnt      <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) q[i] <= q_nxt[i];
            cnt      <= cnt + CNT_W'(disp_fire) - CNT_W'(iss_fire);
            lock_vld <= iss_valid && !bus.iss_ready;
            lock_idx <= sel_idx;
        end
    end
endmodule

// File: tb/tb_res_station_pq.sv
// Directed bench for res_station_pq with an issue scoreboard.
module tb_res_station_pq;
    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    iss_t sb[$];

    res_station_pq_if bus ();

    res_station_pq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [7:0] dst,
                        input logic r1, input logic [7:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [7:0] t2, input logic [31:0] v2);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_dst_tag = dst;
        bus.disp_s1_rdy  = r1;
        bus.disp_s1_tag  = t1;
        bus.disp_s1_val  = v1;
        bus.disp_s2_rdy  = r2;
        bus.disp_s2_tag  = t2;
        bus.disp_s2_val  = v2;
    endtask

    task automatic cdb(input logic [7:0] t, input logic [31:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_val   = v;
    endtask

    task automatic expect_iss(input logic [2:0] op, input logic [7:0] dst,
                              input logic [31:0] a, input logic [31:0] b);
        sb.push_back('{op: op, dst: dst, a: a, b: b});
    endtask

    task automatic chk_offer(input string name, input logic [7:0] dst,
                             input logic [31:0] a, input logic [31:0] b);
        chk(name, {7'd0, bus.iss_valid, bus.iss_dst_tag, bus.iss_a, bus.iss_b},
                  {7'd0, 1'b1, dst, a, b});
    endtask

    task automatic chk_cnt(input string name, input int exp);
        chk(name, 80'(bus.count), 80'(exp));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctrl"}, 80'({bus.disp_ready, bus.iss_valid, bus.count}), 80'({1'b1, 1'b0, 4'd0}));
        chk({name, "_data"}, 80'({bus.iss_op, bus.iss_dst_tag, bus.iss_a, bus.iss_b}), 80'd0);
    endtask

    // Monitor: every accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.iss_valid && bus.iss_ready) begin
            if (sb.size() == 0) begin
                chk("iss_unexpected", 80'(bus.iss_dst_tag), 80'hFFFF);
            end else begin
                iss_t e;
                e = sb.pop_front();
                chk("iss_data", 80'({bus.iss_op, bus.iss_dst_tag, bus.iss_a, bus.iss_b}), 80'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        bus.disp_valid = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_val    = '0;
        bus.iss_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        step();

        // 1: ready entry issues the cycle after dispatch
        bus.iss_ready = 1'b1;
        disp(2, 8'h20, 1, 0, 5, 1, 0, 7);
        expect_iss(2, 8'h20, 5, 7);
        step(); quiet();
        chk_cnt("t1_cnt1", 1);
        chk_offer("t1_offer", 8'h20, 5, 7);
        step();
        chk_cnt("t1_cnt0", 0);

        // 2: CDB wakeup, offered exactly one cycle after the broadcast
        disp(4, 8'h40, 0, 8'h41, 0, 1, 0, 3);
        step(); quiet();
        chk("t2_wait1", 80'(bus.iss_valid), 80'd0);
        step();
        chk("t2_wait2", 80'(bus.iss_valid), 80'd0);
        cdb(8'h41, 100);
        expect_iss(4, 8'h40, 100, 3);
        #1;
        chk("t2_no_comb", 80'(bus.iss_valid), 80'd0);
        step(); quiet();
        chk_offer("t2_offer", 8'h40, 100, 3);
        step();
        chk_cnt("t2_cnt0", 0);

        // 3: fill with waiting entries, drop a dispatch while full
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            disp(2, 8'h30 + 8'(k), 0, 8'h21 + 8'(k), 0, 1, 0, k);
            step();
        end
        quiet();
        chk_cnt("t3_full_cnt", 8);
        chk("t3_full_rdy", 80'(bus.disp_ready), 80'd0);
        chk("t3_none", 80'(bus.iss_valid), 80'd0);
        disp(2, 8'h99, 1, 0, 1, 1, 0, 2);
        step(); quiet();
        chk_cnt("t3_drop_cnt", 8);
        chk("t3_drop_iss", 80'(bus.iss_valid), 80'd0);
        cdb(8'h26, 55);
        step(); quiet();
        chk_offer("t3_e5", 8'h35, 55, 5);

        // 4: held offer survives an older entry becoming ready
        cdb(8'h24, 44);
        step(); quiet();
        chk_offer("t4_hold5a", 8'h35, 55, 5);
        step();
        chk_offer("t4_hold5b", 8'h35, 55, 5);
        expect_iss(2, 8'h35, 55, 5);
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        chk_cnt("t4_cnt7", 7);
        chk_offer("t4_e3", 8'h33, 44, 3);
        step();
        cdb(8'h22, 22);
        step(); quiet();
        chk_offer("t4_hold3a", 8'h33, 44, 3);
        step();
        chk_offer("t4_hold3b", 8'h33, 44, 3);
        expect_iss(2, 8'h33, 44, 3);
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        chk_cnt("t4_cnt6", 6);
        chk_offer("t4_e1", 8'h31, 22, 1);
        expect_iss(2, 8'h31, 22, 1);
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        chk_cnt("t4_cnt5", 5);
        chk("t4_idle", 80'(bus.iss_valid), 80'd0);

        // 5: dispatch with CDB bypass during an issue; capture while shifting
        cdb(8'h21, 10);
        step(); quiet();
        chk_offer("t5_e0", 8'h30, 10, 0);
        expect_iss(2, 8'h30, 10, 0);
        bus.iss_ready = 1'b1;
        disp(4, 8'h50, 0, 8'h82, 0, 1, 0, 6);
        cdb(8'h82, 9);
        step(); quiet();
        bus.iss_ready = 1'b0;
        chk_cnt("t5_cnt_same", 5);
        chk_offer("t5_bypass", 8'h50, 9, 6);
        expect_iss(4, 8'h50, 9, 6);
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        chk_cnt("t5_cnt4", 4);
        cdb(8'h23, 30);
        step(); quiet();
        chk_offer("t5_e2", 8'h32, 30, 2);
        expect_iss(2, 8'h32, 30, 2);
        bus.iss_ready = 1'b1;
        cdb(8'h27, 70);
        step(); quiet();
        bus.iss_ready = 1'b0;
        chk_cnt("t5_cnt3", 3);
        chk_offer("t5_shift_cap", 8'h36, 70, 6);

        // 6: flush beats dispatch; empty ignores CDB; async reset mid-cycle
        disp(3, 8'h60, 0, 8'h90, 0, 0, 8'h91, 0);
        step(); quiet();
        chk_cnt("t6_cnt4", 4);
        bus.flush = 1'b1;
        disp(1, 8'h61, 1, 0, 1, 1, 0, 1);
        #1;
        chk("t6_flush_vis", 80'(bus.iss_valid), 80'd1);
        step(); quiet();
        chk_cnt("t6_flush_cnt", 0);
        chk("t6_flush_iss", 80'({bus.iss_valid, bus.disp_ready}), 80'b01);
        cdb(8'h28, 8);
        step(); quiet();
        chk("t6_empty_cdb", 80'({bus.iss_valid, bus.count}), 80'd0);
        bus.iss_ready = 1'b1;
        disp(1, 8'h70, 1, 0, 1, 1, 0, 2);
        expect_iss(1, 8'h70, 1, 2);
        step(); quiet();
        chk_offer("t6_after_flush", 8'h70, 1, 2);
        step();
        chk_cnt("t6_cnt0", 0);
        bus.iss_ready = 1'b0;
        disp(2, 8'h71, 1, 0, 3, 1, 0, 4);
        step(); quiet();
        chk_offer("t6_pre_rst", 8'h71, 3, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t6_async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk_reset("t6_post_rst");

        chk("sb_drained", 80'(sb.size()), 80'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
